// File: rtl/video_frame_crc.sv
// video_frame_crc
//   Per-frame signature of the emu video output. For every frame between two
//   VS rising edges it measures the active width (first non-empty line), the
//   number of non-empty lines and a reflected CRC-32 (poly 0xEDB88320, init and
//   final XOR 0xFFFFFFFF) over the active pixels, fed as bytes R, G, B, each
//   LSB first. All video inputs are sampled only on ce_pix.
//
//   Ports
//     clk_sys, reset_n (async, active low), ce_pix
//     VGA_R/G/B [7:0], VGA_HS, VGA_VS, VGA_HB, VGA_VB     video input
//     frame_valid          one-cycle pulse when results are latched
//     frame_crc [31:0]     CRC-32 of the last completed frame
//     frame_width          active pixels on the first non-empty line
//     frame_height         lines with at least one active pixel
//     frame_count          completed frames since reset (wrapping)
//     width_err            some non-empty line differed from frame_width
//
//   Build option: define VIDEO_FRAME_CRC_DISPLAY_EN to $display each frame's
//   results on frame_valid (simulation only).
module video_frame_crc #(
    parameter int HCNT_W = 12,
    parameter int VCNT_W = 11,
    parameter int FCNT_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [7:0]        VGA_R,
    input  logic [7:0]        VGA_G,
    input  logic [7:0]        VGA_B,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic              VGA_HB,
    input  logic              VGA_VB,
    output logic              frame_valid,
    output logic [31:0]       frame_crc,
    output logic [HCNT_W-1:0] frame_width,
    output logic [VCNT_W-1:0] frame_height,
    output logic [FCNT_W-1:0] frame_count,
    output logic              width_err
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

    state_t state_q, state_d;

    logic              vs_prev_q, hb_prev_q;
    logic [31:0]       crc_q, crc_d;
    logic [HCNT_W-1:0] line_w_q, line_w_d;
    logic [HCNT_W-1:0] ref_w_q, ref_w_d;
    logic [VCNT_W-1:0] height_q, height_d;
    logic              werr_q, werr_d;

    logic              frame_valid_q;
    logic [31:0]       frame_crc_q;
    logic [HCNT_W-1:0] frame_width_q;
    logic [VCNT_W-1:0] frame_height_q;
    logic [FCNT_W-1:0] frame_count_q;
    logic              width_err_q;

    logic              vs_edge, hb_rise, pix_act, frame_close;
    logic [HCNT_W-1:0] ev_ref, line_base;
    logic [VCNT_W-1:0] ev_height;
    logic              ev_werr;
    logic [31:0]       crc_base;

    // HSYNC carries no information for the signature.
    logic unused_hs;
    assign unused_hs = VGA_HS;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign vs_edge = ce_pix & VGA_VS & ~vs_prev_q;
    assign hb_rise = ce_pix & VGA_HB & ~hb_prev_q;
    assign pix_act = ce_pix & ~VGA_HB & ~VGA_VB;

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= WAIT_SYNC;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_SYNC && vs_edge) state_d = ACTIVE;
    end

    // FSM output: only frames opened by an earlier VS edge are reported
    always_comb begin
        frame_close = (state_q == ACTIVE) && vs_edge;
    end

    // Line-end evaluation happens before the frame-close snapshot, so an HB
    // edge on the VS-edge sample still lands in the closing frame.
    always_comb begin
        ev_ref    = ref_w_q;
        ev_height = height_q;
        ev_werr   = werr_q;
        if (hb_rise && line_w_q != '0) begin
            if (ref_w_q == '0)          ev_ref  = line_w_q;
            else if (line_w_q != ref_w_q) ev_werr = 1'b1;
            if (height_q != '1)         ev_height = height_q + VCNT_W'(1);
        end
    end

    // Accumulator update: a VS edge restarts from the cleared state first, so
    // a pixel on that same sample is the first pixel of the new frame.
    always_comb begin
        if (vs_edge) begin
            crc_base  = CRC_INIT;
            line_base = '0;
            ref_w_d   = '0;
            height_d  = '0;
            werr_d    = 1'b0;
        end else begin
            crc_base  = crc_q;
            line_base = hb_rise ? '0 : line_w_q;
            ref_w_d   = ev_ref;
            height_d  = ev_height;
            werr_d    = ev_werr;
        end
        crc_d    = crc_base;
        line_w_d = line_base;
        if (pix_act) begin
            crc_d = crc_byte(crc_byte(crc_byte(crc_base, VGA_R), VGA_G), VGA_B);
            if (line_base != '1) line_w_d = line_base + HCNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q      <= 1'b0;
            hb_prev_q      <= 1'b0;
            crc_q          <= CRC_INIT;
            line_w_q       <= '0;
            ref_w_q        <= '0;
            height_q       <= '0;
            werr_q         <= 1'b0;
            frame_valid_q  <= 1'b0;
            frame_crc_q    <= '0;
            frame_width_q  <= '0;
            frame_height_q <= '0;
            frame_count_q  <= '0;
            width_err_q    <= 1'b0;
        end else begin
            if (ce_pix) begin
                vs_prev_q <= VGA_VS;
                hb_prev_q <= VGA_HB;
            end
            crc_q         <= crc_d;
            line_w_q      <= line_w_d;
            ref_w_q       <= ref_w_d;
            height_q      <= height_d;
            werr_q        <= werr_d;
            frame_valid_q <= frame_close;
            if (frame_close) begin
                frame_crc_q    <= crc_q ^ CRC_INIT;
                frame_width_q  <= ev_ref;
                frame_height_q <= ev_height;
                width_err_q    <= ev_werr;
                frame_count_q  <= frame_count_q + FCNT_W'(1);
            end
        end
    end

    assign frame_valid  = frame_valid_q;
    assign frame_crc    = frame_crc_q;
    assign frame_width  = frame_width_q;
    assign frame_height = frame_height_q;
    assign frame_count  = frame_count_q;
    assign width_err    = width_err_q;

`ifdef VIDEO_FRAME_CRC_DISPLAY_EN
    always_ff @(posedge clk_sys) begin
        if (frame_valid_q)
            $display("video_frame_crc: frame %0d %0dx%0d crc=%08h width_err=%0d",
                     frame_count_q, frame_width_q, frame_height_q, frame_crc_q, width_err_q);
    end
`else
    // No per-frame console report in this build.
`endif

endmodule

// File: tb/tb_video_frame_crc.sv
module tb_video_frame_crc;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_pix  = 1'b0;
    logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic        VGA_HS = 1'b0, VGA_VS = 1'b0, VGA_HB = 1'b1, VGA_VB = 1'b1;
    logic        frame_valid;
    logic [31:0] frame_crc;
    logic [11:0] frame_width;
    logic [10:0] frame_height;
    logic [15:0] frame_count;
    logic        width_err;

    video_frame_crc #(.HCNT_W(12), .VCNT_W(11), .FCNT_W(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_HB(VGA_HB), .VGA_VB(VGA_VB),
        .frame_valid(frame_valid), .frame_crc(frame_crc), .frame_width(frame_width),
        .frame_height(frame_height), .frame_count(frame_count), .width_err(width_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int exp_cnt = 0;

    always @(negedge clk_sys) if (frame_valid === 1'b1) n_valid++;

    typedef struct packed {
        logic [1:0]       n;
        logic [2:0][23:0] px;
        logic             gap;
        logic [31:0]      crc;
        logic [11:0]      w;
        logic [10:0]      h;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [23:0] p0, input logic [23:0] p1,
                                input logic [23:0] p2, input logic gap, input logic [31:0] crc,
                                input int w, input int h);
        vec_t v;
        v.n = 2'(n); v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.gap = gap;
        v.crc = crc; v.w = 12'(w); v.h = 11'(h);
        return v;
    endfunction

    // Bit-serial reference CRC-32 (reflected), one pixel = bytes R, G, B
    function automatic logic [31:0] model_px(input logic [31:0] c_in, input logic [23:0] px);
        logic [31:0] c;
        logic [7:0]  by;
        logic        fb;
        c = c_in;
        for (int k = 0; k < 3; k++) begin
            by = (k == 0) ? px[23:16] : (k == 1) ? px[15:8] : px[7:0];
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ by[b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic vs, input logic hb, input logic vb,
                         input logic [23:0] px);
        ce_pix = ce; VGA_VS = vs; VGA_HB = hb; VGA_VB = vb; VGA_HS = hb;
        VGA_R = px[23:16]; VGA_G = px[15:8]; VGA_B = px[7:0];
        @(posedge clk_sys);
        #1;
    endtask

    task automatic blank(input logic vs);
        drive(1'b1, vs, 1'b1, 1'b1, 24'h000000);
    endtask

    task automatic line(input int n, input logic [23:0] px);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, px);
    endtask

    // VS edge sample closes the frame; results must appear right after it
    task automatic close_chk(input string nm, input logic [31:0] crc, input int w, input int h,
                             input logic err);
        blank(1'b1);
        exp_cnt++;
        chk({nm, " valid"},  32'(frame_valid), 32'd1);
        chk({nm, " crc"},    frame_crc, crc);
        chk({nm, " width"},  32'(frame_width), 32'(w));
        chk({nm, " height"}, 32'(frame_height), 32'(h));
        chk({nm, " werr"},   32'(width_err), 32'(err));
        chk({nm, " count"},  32'(frame_count), 32'(exp_cnt & 16'hFFFF));
        blank(1'b0);
        chk({nm, " pulse"},  32'(frame_valid), 32'd0);
        chk({nm, " hold"},   frame_crc, crc);
    endtask

    vec_t vecs[4];

    initial begin
        logic [31:0] mc;
        int          nv;
        int          widths[4];

        vecs[0] = mk(3, 24'h313233, 24'h343536, 24'h373839, 1'b0, 32'hCBF43926, 3, 1);
        vecs[1] = mk(1, 24'h000000, 24'h000000, 24'h000000, 1'b0, 32'hFF41D912, 1, 1);
        vecs[2] = mk(0, 24'h000000, 24'h000000, 24'h000000, 1'b0, 32'h00000000, 0, 0);
        vecs[3] = mk(3, 24'h313233, 24'h343536, 24'h373839, 1'b1, 32'hCBF43926, 3, 1);

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst valid",  32'(frame_valid), 0);
        chk("rst crc",    frame_crc, 0);
        chk("rst width",  32'(frame_width), 0);
        chk("rst height", 32'(frame_height), 0);
        chk("rst count",  32'(frame_count), 0);
        chk("rst werr",   32'(width_err), 0);
        reset_n = 1'b1;

        // Partial frame before the first VS edge is discarded
        blank(1'b0);
        line(4, 24'h55AA55);
        blank(1'b0);
        blank(1'b1);
        blank(1'b0);
        chk("first vs no valid", 32'(n_valid), 0);

        // Single-line frames from the table
        for (int i = 0; i < 4; i++) begin
            blank(1'b0);
            for (int p = 0; p < int'(vecs[i].n); p++) begin
                if (vecs[i].gap && p > 0)
                    repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
                drive(1'b1, 1'b0, 1'b0, 1'b0, vecs[i].px[p]);
            end
            blank(1'b0);
            close_chk($sformatf("vec%0d", i), vecs[i].crc, int'(vecs[i].w), int'(vecs[i].h), 1'b0);
        end
        chk("valid pulses", 32'(n_valid), 4);

        // HB edge on the VS-edge sample belongs to the closing frame
        line(1, 24'h313233); line(1, 24'h343536); line(1, 24'h373839);
        close_chk("hb_on_vs", 32'hCBF43926, 3, 1, 1'b0);

        // Active pixel on the VS-edge sample belongs to the new frame
        line(1, 24'h000000);
        blank(1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 24'h313233);
        exp_cnt++;
        chk("pix_on_vs valid", 32'(frame_valid), 1);
        chk("pix_on_vs crc",   frame_crc, 32'hFF41D912);
        chk("pix_on_vs width", 32'(frame_width), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h343536);
        chk("pix_on_vs pulse", 32'(frame_valid), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h373839);
        blank(1'b0);
        close_chk("pix_next", 32'hCBF43926, 3, 1, 1'b0);

        // Multi-line frame with one short line, then a clean frame
        widths = '{320, 320, 319, 320};
        mc = 32'hFFFFFFFF;
        for (int l = 0; l < 4; l++) begin
            line(widths[l], 24'h102030);
            for (int k = 0; k < widths[l]; k++) mc = model_px(mc, 24'h102030);
            if (l == 1) drive(1'b1, 1'b0, 1'b0, 1'b1, 24'hABCDEF);  // VB blanks this sample
            blank(1'b0);
        end
        close_chk("short_line", mc ^ 32'hFFFFFFFF, 320, 4, 1'b1);
        for (int l = 0; l < 4; l++) begin
            line(320, 24'h102030);
            blank(1'b0);
        end
        mc = 32'hFFFFFFFF;
        for (int k = 0; k < 1280; k++) mc = model_px(mc, 24'h102030);
        close_chk("clean", mc ^ 32'hFFFFFFFF, 320, 4, 1'b0);

        // Reset mid-frame: asynchronous clear, back to waiting for sync
        nv = n_valid;
        line(7, 24'h010203);
        #3 reset_n = 1'b0;
        #1;
        chk("async rst crc",   frame_crc, 0);
        chk("async rst count", 32'(frame_count), 0);
        chk("async rst width", 32'(frame_width), 0);
        chk("async rst height", 32'(frame_height), 0);
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        exp_cnt = 0;
        line(3, 24'h040506);
        blank(1'b0);
        blank(1'b1);
        blank(1'b0);
        chk("after rst no valid", 32'(n_valid - nv), 0);
        chk("after rst count",    32'(frame_count), 0);
        line(1, 24'h000000);
        blank(1'b0);
        close_chk("after rst", 32'hFF41D912, 1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
